// File: rtl/sha256_msg_sequencer_pkg.sv
// Shared SHA256 constants: word width, round counts and the message sequencer state encoding.
`ifndef WORD
`define WORD 32
`endif

package sha256_msg_sequencer_pkg;

  localparam int unsigned WORD_WIDTH  = `WORD;
  localparam int unsigned ROUNDS      = 64;
  localparam int unsigned MSG_WORDS   = 16;
  localparam int unsigned CNT_WIDTH   = 7;
  localparam int unsigned ROUND_WIDTH = 6;

  localparam logic [CNT_WIDTH-1:0]   CNT_LAST_WORD  = CNT_WIDTH'(MSG_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST_ROUND = CNT_WIDTH'(ROUNDS - 1);
  localparam logic [ROUND_WIDTH-1:0] ROUND_LAST     = ROUND_WIDTH'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sha256_msg_sequencer.sv
// Sequences one 16-word block into the SHA256 message scheduler and streams W_0..W_63 out.
// Build option: define SHA256_SEQ_AUTOSTART_EN to leave IDLE on s_valid instead of start.
module sha256_msg_sequencer
  import sha256_msg_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  s_word,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  output logic                   sch_en,
  output logic                   sch_load,
  output logic [WORD_WIDTH-1:0]  sch_msg,
  input  logic [WORD_WIDTH-1:0]  sch_w,
  output logic [WORD_WIDTH-1:0]  w_data,
  output logic [ROUND_WIDTH-1:0] w_round,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic                   w_last,
  output logic                   busy,
  output logic                   done
);

  seq_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   last_blk_q, last_blk_d;
  logic                   w_valid_q, w_valid_d;
  logic [ROUND_WIDTH-1:0] w_round_q, w_round_d;
  logic                   done_q, done_d;

  logic go_c;
  logic adv_c;
  logic s_ready_c;
  logic sch_en_c;
  logic sch_load_c;

`ifdef SHA256_SEQ_AUTOSTART_EN
  assign go_c = s_valid;
`else
  assign go_c = start;
`endif

  // The scheduler only shifts when the output slot is empty or being drained.
  assign adv_c = !w_valid_q || w_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_blk_d = last_blk_q;
    w_valid_d  = w_valid_q;
    w_round_d  = w_round_q;
    done_d     = 1'b0;
    s_ready_c  = 1'b0;
    sch_en_c   = 1'b0;
    sch_load_c = 1'b0;

    unique case (state_q)
      // A start in the done cycle is dropped so a new block never overlaps done.
      ST_IDLE: begin
        if (go_c && !done_q) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sch_load_c = 1'b1;
        s_ready_c  = adv_c;
        sch_en_c   = s_valid && adv_c;
        if (sch_en_c && (cnt_q == CNT_LAST_WORD)) begin
          last_blk_d = s_last;
          state_d    = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        sch_en_c = adv_c;
        if (adv_c && (cnt_q == CNT_LAST_ROUND)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_valid_q && w_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sch_en_c) begin
      cnt_d     = cnt_q + CNT_WIDTH'(1);
      w_valid_d = 1'b1;
      w_round_d = cnt_q[ROUND_WIDTH-1:0];
    end else if (w_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_blk_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_round_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_blk_q <= last_blk_d;
      w_valid_q  <= w_valid_d;
      w_round_q  <= w_round_d;
      done_q     <= done_d;
    end
  end

  assign s_ready  = s_ready_c;
  assign sch_en   = sch_en_c;
  assign sch_load = sch_load_c;
  assign sch_msg  = s_word;
  assign w_data   = sch_w;
  assign w_round  = w_round_q;
  assign w_valid  = w_valid_q;
  assign w_last   = last_blk_q && w_valid_q && (w_round_q == ROUND_LAST);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Self-checking bench: behavioural scheduler, software W_t reference, scenario table plus reset/back-to-back sequences.
module tb_sha256_msg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] s_word = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        w_ready = 1'b1;
  logic        s_ready, sch_en, sch_load, w_valid, w_last, busy, done;
  logic [31:0] sch_msg, sch_w, w_data;
  logic [5:0]  w_round;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] blk[16];
  logic [31:0] exp_w[64];
  logic [31:0] h[16];

  int r_done, r_sready, r_got, r_first;
  bit r_fin;

  typedef struct {
    logic last;
    int   gap_after;
    int   gap_len;
    int   stall_round;
    int   stall_len;
    int   exp_done;
    int   exp_sready;
  } vec_t;

  sha256_msg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_word(s_word), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .sch_en(sch_en), .sch_load(sch_load), .sch_msg(sch_msg), .sch_w(sch_w),
    .w_data(w_data), .w_round(w_round), .w_valid(w_valid), .w_ready(w_ready),
    .w_last(w_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Scheduler stand-in: h[15] is the newest word, h[0] is W_{t-16}.
  always @(posedge clk) begin
    if (sch_en) begin
      for (int i = 0; i < 15; i++) h[i] <= h[i+1];
      h[15] <= sch_load ? sch_msg : (sig1(h[14]) + h[9] + sig0(h[1]) + h[0]);
    end
  end
  assign sch_w = h[15];

  task automatic compute_exp();
    for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      exp_w[t] = sig1(exp_w[t-2]) + exp_w[t-7] + sig0(exp_w[t-15]) + exp_w[t-16];
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    compute_exp();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_block(input logic last, input int gap_after, input int gap_len,
                           input int stall_round, input int stall_len, input int abort_round);
    int t0;
    @(posedge clk); #1;
`ifndef SHA256_SEQ_AUTOSTART_EN
    start = 1'b1;
`endif
    t0 = cyc;
    r_done = -1; r_sready = 0; r_got = 0; r_first = -1; r_fin = 1'b0;
    fork
      begin
        bit acc;
        for (int i = 0; i < 16; i++) begin
          acc = 1'b0;
          s_word  = blk[i];
          s_last  = (i == 15) ? last : !last;
          s_valid = 1'b1;
          for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            if (s_ready) begin
              acc = 1'b1;
              chk($sformatf("load_ctl%0d", i), {30'd0, sch_en, sch_load, sch_msg},
                  {30'd0, 2'b11, blk[i]});
            end
            @(posedge clk); #1;
          end
          if (!acc) begin
            chk("src_timeout", 64'd0, 64'd1);
            break;
          end
          if (i == gap_after) begin
            s_valid = 1'b0;
            repeat (gap_len) begin
              @(negedge clk);
              chk("gap_en", {63'd0, sch_en}, 64'd0);
              @(posedge clk); #1;
            end
          end
        end
        s_valid = 1'b0;
      end
      begin
        int stall_left;
        bit stall_pend;
        logic [31:0] hd;
        logic [5:0]  hr;
        stall_left = 0;
        stall_pend = (stall_round >= 0);
        hd = 32'd0;
        hr = 6'd0;
        for (int k = 0; k < 400 && !r_fin; k++) begin
          if (k == 1) start = 1'b0;
          if (abort_round >= 0 && w_valid && w_round == 6'(abort_round)) begin
            rst_n = 1'b0;
            #1;
            chk("abort_outs", {51'd0, s_ready, sch_en, sch_load, w_valid, w_round, w_last, busy, done},
                64'd0);
            r_fin = 1'b1;
          end else begin
            if (stall_pend && w_valid && w_round == 6'(stall_round)) begin
              stall_pend = 1'b0;
              stall_left = stall_len;
              hd = w_data;
              hr = w_round;
            end
            w_ready = (stall_left == 0);
            @(negedge clk);
            if (s_ready) r_sready++;
            if (stall_left > 0) begin
              chk("stall_hold", {24'd0, w_valid, sch_en, w_round, w_data}, {24'd0, 1'b1, 1'b0, hr, hd});
              stall_left--;
            end else if (w_valid && w_ready) begin
              if (r_got == 0) r_first = cyc - t0;
              if (r_got < 64)
                chk($sformatf("w%0d", r_got), {25'd0, w_last, w_round, w_data},
                    {25'd0, (last && r_got == 63), 6'(r_got), exp_w[r_got]});
              else
                chk("extra_word", 64'd1, 64'd0);
              r_got++;
            end
            if (done) begin
              r_done = cyc - t0;
              r_fin  = 1'b1;
            end else begin
              @(posedge clk); #1;
            end
          end
        end
        if (!r_fin) chk("sink_timeout", 64'd0, 64'd1);
        w_ready = 1'b1;
      end
    join
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{1'b1, -1, 0, -1, 0, 66, 16};
    vecs[1] = '{1'b1, -1, 0, 20, 5, 71, 16};
    vecs[2] = '{1'b1,  7, 3, -1, 0, 69, 19};
    vecs[3] = '{1'b0, -1, 0, -1, 0, 66, 16};

    #2;
    chk("reset_outs", {51'd0, s_ready, sch_en, sch_load, w_valid, w_round, w_last, busy, done}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    load_abc();
    chk("abc_w16", {32'd0, exp_w[16]}, 64'h61626380);
    chk("abc_w17", {32'd0, exp_w[17]}, 64'h000F0000);

    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].last, vecs[v].gap_after, vecs[v].gap_len,
                vecs[v].stall_round, vecs[v].stall_len, -1);
      chki($sformatf("v%0d_done_cyc", v), r_done, vecs[v].exp_done);
      chki($sformatf("v%0d_words", v), r_got, 64);
      chki($sformatf("v%0d_sready_cyc", v), r_sready, vecs[v].exp_sready);
      chki($sformatf("v%0d_first_cyc", v), r_first, 2);
    end

`ifndef SHA256_SEQ_AUTOSTART_EN
    // A start presented during the done cycle must not be taken.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done", {62'd0, busy, s_ready}, 64'd0);
`endif

    // Four blocks, each started in the cycle right after the previous done.
    for (int b = 0; b < 4; b++) begin
      if (b == 0) load_abc();
      else begin
        for (int i = 0; i < 16; i++) blk[i] = 32'h9E3779B9 * 32'(b * 16 + i + 1);
        compute_exp();
      end
      run_block(b == 3, -1, 0, -1, 0, -1);
      chki($sformatf("b%0d_done_cyc", b), r_done, 66);
      chki($sformatf("b%0d_words", b), r_got, 64);
      chki($sformatf("b%0d_sready_cyc", b), r_sready, 16);
    end

    // Reset while W_30 is presented, then a clean abc block.
    load_abc();
    run_block(1'b1, -1, 0, -1, 0, 30);
    chki("abort_seen", int'(r_fin), 1);
    @(posedge clk); #1;
    chk("abort_held", {62'd0, busy, w_valid}, 64'd0);
    rst_n = 1'b1;
    run_block(1'b1, -1, 0, -1, 0, -1);
    chki("post_rst_done_cyc", r_done, 66);
    chki("post_rst_words", r_got, 64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
